// File: rtl/if_stage.sv
// Instruction fetch stage: holds the PC, issues one instruction-memory request at a time, registers the result for decode.
// Latency: request accepted -> data_ok -> id_valid next cycle; minimum 3 cycles per instruction.
// Backpressure: id_ready low holds the instruction in HOLD and no new request is issued until it is consumed.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   inst_req/inst_addr  fetch request valid / address (= pc); inst_addr_ok accepts it
//   inst_rdata/data_ok  returned instruction word and its valid strobe
//   redirect/_pc        branch/jump/exception redirect pulse and target (word aligned here)
//   id_ready            decode consumes id_* this cycle
//   id_valid/pc/instr   held instruction for decode; id_imm = id_instr[15:0]
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic [31:0] inst_rdata,
   input  logic        inst_data_ok,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   output logic [15:0] id_imm
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic        discard, discard_nxt;
   logic        id_valid_nxt;
   logic        capture;
   logic [31:0] redirect_al;

   // State resets to REQ, so the request is masked while reset is held.
   assign inst_req    = (state == S_REQ) && rst_n;
   assign inst_addr   = pc;
   assign id_imm      = id_instr[15:0];
   assign redirect_al = {redirect_pc[31:2], 2'b00};

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      discard_nxt  = discard;
      id_valid_nxt = id_valid;
      capture      = 1'b0;
      case (state)
         S_REQ: begin
            if (inst_addr_ok) begin
               state_nxt = S_WAIT;
               // A redirect in the accept cycle makes the request just issued stale.
               discard_nxt = redirect;
            end
            if (redirect) begin
               pc_nxt = redirect_al;
            end
         end
         S_WAIT: begin
            if (redirect) begin
               pc_nxt = redirect_al;
               if (inst_data_ok) begin
                  // Response arrives with the redirect: drop it, nothing left in flight.
                  state_nxt   = S_REQ;
                  discard_nxt = 1'b0;
               end else begin
                  discard_nxt = 1'b1;
               end
            end else if (inst_data_ok) begin
               state_nxt   = S_REQ;
               discard_nxt = 1'b0;
               if (!discard) begin
                  state_nxt    = S_HOLD;
                  capture      = 1'b1;
                  id_valid_nxt = 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (redirect) begin
               pc_nxt       = redirect_al;
               id_valid_nxt = 1'b0;
               state_nxt    = S_REQ;
            end else if (id_ready) begin
               pc_nxt       = pc + 32'd4;
               id_valid_nxt = 1'b0;
               state_nxt    = S_REQ;
            end
         end
         default: begin
            state_nxt = S_REQ;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_REQ;
         pc       <= RESET_PC;
         discard  <= 1'b0;
         id_valid <= 1'b0;
         id_pc    <= '0;
         id_instr <= '0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         discard  <= discard_nxt;
         id_valid <= id_valid_nxt;
         if (capture) begin
            id_pc    <= pc;
            id_instr <= inst_rdata;
         end
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed fetch sequences with a scoreboard of expected
// request addresses and expected decode-side instructions.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic [31:0] inst_rdata;
   logic        inst_data_ok;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic [15:0] id_imm;

   always #5 clk = ~clk;

   if_stage #(.RESET_PC(32'hBFC0_0000)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_rdata   (inst_rdata),
      .inst_data_ok (inst_data_ok),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .id_ready     (id_ready),
      .id_valid     (id_valid),
      .id_pc        (id_pc),
      .id_instr     (id_instr),
      .id_imm       (id_imm)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } id_exp_t;

   logic [31:0] exp_addr_q[$];
   id_exp_t     exp_id_q[$];
   int          n_pass  = 0;
   int          n_total = 0;
   bit          stale_seen = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: pops the scoreboard whenever the DUT completes a handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (inst_req && inst_addr_ok) begin
            if (exp_addr_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_req: got addr %h expected no request (t=%0t)", inst_addr, $time);
            end else begin
               chk("req_addr", inst_addr, exp_addr_q.pop_front());
            end
         end
         if (id_valid && id_ready) begin
            if (exp_id_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_id: got pc %h instr %h expected nothing (t=%0t)", id_pc, id_instr, $time);
            end else begin
               id_exp_t e;
               e = exp_id_q.pop_front();
               chk("id_pc", id_pc, e.pc);
               chk("id_instr", id_instr, e.instr);
               chk("id_imm", {16'h0, id_imm}, {16'h0, e.instr[15:0]});
            end
         end
         if (id_valid && id_instr == 32'hDEAD_BEEF) stale_seen = 1'b1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete fetch starting with the DUT in REQ; leaves it in REQ.
   task automatic do_fetch(input logic [31:0] exp_pc, input int addr_wait, input int data_wait,
                           input logic [31:0] word, input int hold);
      bit ok;
      exp_addr_q.push_back(exp_pc);
      exp_id_q.push_back({exp_pc, word});
      ok = 1'b1;
      repeat (addr_wait) begin
         inst_addr_ok = 1'b0;
         @(negedge clk);
         if (!(inst_req && inst_addr == exp_pc)) ok = 1'b0;
         step();
      end
      if (addr_wait > 0) chk("req_held", {31'h0, ok}, 32'h1);
      inst_addr_ok = 1'b1;
      step();
      inst_addr_ok = 1'b0;
      repeat (data_wait) step();
      inst_data_ok = 1'b1;
      inst_rdata   = word;
      step();
      inst_data_ok = 1'b0;
      inst_rdata   = 32'h0BAD_0BAD;
      ok = 1'b1;
      repeat (hold) begin
         id_ready = 1'b0;
         @(negedge clk);
         if (!(id_valid && id_pc == exp_pc && id_instr == word && !inst_req)) ok = 1'b0;
         step();
      end
      if (hold > 0) chk("hold_stable", {31'h0, ok}, 32'h1);
      id_ready = 1'b1;
      step();
      id_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n        = 1'b0;
      inst_addr_ok = 1'b0;
      inst_rdata   = '0;
      inst_data_ok = 1'b0;
      redirect     = 1'b0;
      redirect_pc  = '0;
      id_ready     = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_req", {31'h0, inst_req}, 32'h0);
      chk("rst_valid", {31'h0, id_valid}, 32'h0);
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_id_instr", id_instr, 32'h0);
      chk("rst_addr", inst_addr, 32'hBFC0_0000);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("first_req", {31'h0, inst_req}, 32'h1);
      chk("first_addr", inst_addr, 32'hBFC0_0000);
      step();

      // 1: back-to-back minimal fetch, 2: held by decode, 3: delayed accept
      do_fetch(32'hBFC0_0000, 0, 0, 32'h2408_FFFF, 0);
      do_fetch(32'hBFC0_0004, 0, 1, 32'h3C01_1234, 5);
      do_fetch(32'hBFC0_0008, 3, 0, 32'h8C22_0010, 0);

      // 4: redirect while waiting; stale response arrives two cycles later
      exp_addr_q.push_back(32'hBFC0_000C);
      inst_addr_ok = 1'b1;
      step();
      inst_addr_ok = 1'b0;
      redirect     = 1'b1;
      redirect_pc  = 32'h8000_0100;
      step();
      redirect = 1'b0;
      step();
      inst_data_ok = 1'b1;
      inst_rdata   = 32'hDEAD_BEEF;
      step();
      inst_data_ok = 1'b0;
      @(negedge clk);
      chk("drop_valid", {31'h0, id_valid}, 32'h0);
      chk("redir_addr", inst_addr, 32'h8000_0100);
      step();
      do_fetch(32'h8000_0100, 0, 0, 32'hAC43_0004, 0);

      // Redirect in REQ without accept, to the top of the address space; pc wraps
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFE;
      step();
      redirect = 1'b0;
      do_fetch(32'hFFFF_FFFC, 0, 0, 32'h2402_0007, 0);
      do_fetch(32'h0000_0000, 1, 0, 32'h0800_8001, 0);

      // 5: redirect coincident with data_ok, unaligned target
      exp_addr_q.push_back(32'h0000_0004);
      inst_addr_ok = 1'b1;
      step();
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b1;
      inst_rdata   = 32'hDEAD_BEEF;
      redirect     = 1'b1;
      redirect_pc  = 32'h8000_0203;
      step();
      inst_data_ok = 1'b0;
      redirect     = 1'b0;
      @(negedge clk);
      chk("coinc_valid", {31'h0, id_valid}, 32'h0);
      chk("coinc_addr", inst_addr, 32'h8000_0200);
      step();
      do_fetch(32'h8000_0200, 0, 0, 32'h1234_ABCD, 0);

      // 6: asynchronous reset in WAIT, late data_ok during and after reset
      exp_addr_q.push_back(32'h8000_0204);
      inst_addr_ok = 1'b1;
      step();
      inst_addr_ok = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_req", {31'h0, inst_req}, 32'h0);
      chk("arst_id_pc", id_pc, 32'h0);
      chk("arst_id_instr", id_instr, 32'h0);
      chk("arst_addr", inst_addr, 32'hBFC0_0000);
      inst_data_ok = 1'b1;
      inst_rdata   = 32'hDEAD_BEEF;
      step();
      rst_n = 1'b1;
      step();
      inst_data_ok = 1'b0;
      @(negedge clk);
      chk("late_ok_valid", {31'h0, id_valid}, 32'h0);
      chk("restart_req", {31'h0, inst_req}, 32'h1);
      chk("restart_addr", inst_addr, 32'hBFC0_0000);
      step();
      do_fetch(32'hBFC0_0000, 0, 0, 32'h2408_0001, 0);

      repeat (3) step();
      chk("addr_q_empty", exp_addr_q.size(), 32'h0);
      chk("id_q_empty", exp_id_q.size(), 32'h0);
      chk("no_stale_word", {31'h0, stale_seen}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
